// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-port snoop bundle.
package regfile_pkg;

  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_NUM_REGS = 2 ** RF_ADDR_W;

  // Write-port view shared by the write side and any reader that snoops it.
  typedef struct packed {
    logic                 en;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wr_snoop_t;

endpackage

// File: rtl/regfile_fwd_mux.sv
// Read-data select: hard-wired zero, then same-edge write forward, then array.
module regfile_fwd_mux #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [DATA_W-1:0] data_o_c
);

  // Zero register wins over a forwarded write so index 0 never reads non-zero.
  always_comb begin
    data_o_c = rf_data_i;
    if (ZERO_R0 && (addr_i == '0)) begin
      data_o_c = '0;
    end else if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o_c = wr_data_i;
    end
  end

endmodule

// File: rtl/regfile_rd_port.sv
// Two-stage read port: address stage A drives the array, response stage R
// snapshots the word and holds it until the consumer takes it.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter bit          ZERO_R0 = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              i_CLK,
  input  logic              i_ASRST,
  input  logic              i_REQ_VALID,
  output logic              o_REQ_READY,
  input  logic [ADDR_W-1:0] i_REQ_ADDR,
  output logic [ADDR_W-1:0] o_RF_ADDR,
  input  logic [DATA_W-1:0] i_RF_DATA,
  input  logic              i_WR_EN,
  input  logic [ADDR_W-1:0] i_WR_ADDR,
  input  logic [DATA_W-1:0] i_WR_DATA,
  output logic              o_RSP_VALID,
  input  logic              i_RSP_READY,
  output logic [DATA_W-1:0] o_RSP_DATA,
  output logic [ADDR_W-1:0] o_RSP_ADDR,
  output logic [CNT_W-1:0]  o_RD_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              a_valid_q,   a_valid_d;
  logic [ADDR_W-1:0] a_addr_q,    a_addr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q,  rsp_addr_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic              advance_c;
  logic              accept_c;
  logic              complete_c;
  logic [DATA_W-1:0] sel_data_c;

  regfile_fwd_mux #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_fwd_mux (
    .addr_i    (a_addr_q),
    .wr_en_i   (i_WR_EN),
    .wr_addr_i (i_WR_ADDR),
    .wr_data_i (i_WR_DATA),
    .rf_data_i (i_RF_DATA),
    .data_o_c  (sel_data_c)
  );

  // Handshake terms; ready looks through a draining A stage for full throughput.
  always_comb begin
    advance_c   = a_valid_q && (!rsp_valid_q || i_RSP_READY);
    o_REQ_READY = !a_valid_q || advance_c;
    accept_c    = i_REQ_VALID && o_REQ_READY;
    complete_c  = rsp_valid_q && i_RSP_READY;
  end

  // Next state for both stages and the saturating completion counter.
  always_comb begin
    a_valid_d   = a_valid_q;
    a_addr_d    = a_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    cnt_d       = cnt_q;

    if (accept_c) begin
      a_valid_d = 1'b1;
      a_addr_d  = i_REQ_ADDR;
    end else if (advance_c) begin
      a_valid_d = 1'b0;
    end

    if (advance_c) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = sel_data_c;
      rsp_addr_d  = a_addr_q;
    end else if (complete_c) begin
      rsp_valid_d = 1'b0;
    end

    if (complete_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops any in-flight request or response.
  always_ff @(posedge i_CLK or negedge i_ASRST) begin
    if (!i_ASRST) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      cnt_q       <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_RF_ADDR   = a_addr_q;
  assign o_RSP_VALID = rsp_valid_q;
  assign o_RSP_DATA  = rsp_data_q;
  assign o_RSP_ADDR  = rsp_addr_q;
  assign o_RD_CNT    = cnt_q;

endmodule

// File: tb/tb_regfile_rd_port.sv
// Directed bench for regfile_rd_port with a behavioural register array.
module tb_regfile_rd_port;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic [CW-1:0] rd_cnt;

  logic [DW-1:0] rf [32];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs [6];
  logic [DW-1:0] b2b_exp [4];

  always #5 clk = ~clk;

  assign rf_data = rf[rf_addr];

  regfile_rd_port #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .ZERO_R0 (1'b1),
    .CNT_W   (CW)
  ) dut (
    .i_CLK       (clk),
    .i_ASRST     (rst_n),
    .i_REQ_VALID (req_valid),
    .o_REQ_READY (req_ready),
    .i_REQ_ADDR  (req_addr),
    .o_RF_ADDR   (rf_addr),
    .i_RF_DATA   (rf_data),
    .i_WR_EN     (wr_en),
    .i_WR_ADDR   (wr_addr),
    .i_WR_DATA   (wr_data),
    .o_RSP_VALID (rsp_valid),
    .i_RSP_READY (rsp_ready),
    .o_RSP_DATA  (rsp_data),
    .o_RSP_ADDR  (rsp_addr),
    .o_RD_CNT    (rd_cnt)
  );

  // One clock: the array takes the snooped write at the edge, inputs change 1ns later.
  task automatic step();
    @(posedge clk);
    if (wr_en) rf[wr_addr] <= wr_data;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    for (int i = 0; i < 32; i++) rf[i] <= 32'h1000_0000 | 32'(i);
    rf[3] <= 32'hDEAD_BEEF;
    rf[0] <= 32'hFFFF_FFFF;

    vecs[0] = '{addr: 5'd3,  wr_en: 1'b0, wr_addr: 5'd0, wr_data: 32'h0,         exp_data: 32'hDEAD_BEEF};
    vecs[1] = '{addr: 5'd7,  wr_en: 1'b1, wr_addr: 5'd7, wr_data: 32'h1234_5678, exp_data: 32'h1234_5678};
    vecs[2] = '{addr: 5'd0,  wr_en: 1'b1, wr_addr: 5'd0, wr_data: 32'h0000_AAAA, exp_data: 32'h0};
    vecs[3] = '{addr: 5'd5,  wr_en: 1'b1, wr_addr: 5'd6, wr_data: 32'h0000_0055, exp_data: 32'h1000_0005};
    vecs[4] = '{addr: 5'd31, wr_en: 1'b0, wr_addr: 5'd0, wr_data: 32'h0,         exp_data: 32'h1000_001F};
    vecs[5] = '{addr: 5'd0,  wr_en: 1'b0, wr_addr: 5'd0, wr_data: 32'h0,         exp_data: 32'h0};
    b2b_exp[0] = 32'h1000_0001;
    b2b_exp[1] = 32'h1000_0002;
    b2b_exp[2] = 32'hDEAD_BEEF;
    b2b_exp[3] = 32'h1000_0004;

    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data,       32'd0);
    chk("rst_rsp_addr",  32'(rsp_addr),  32'd0);
    chk("rst_rf_addr",   32'(rf_addr),   32'd0);
    chk("rst_rd_cnt",    32'(rd_cnt),    32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;

    // Single reads, each with its own snoop pattern on the advancing edge.
    for (int v = 0; v < 6; v++) begin
      req_valid = 1'b1;
      req_addr  = vecs[v].addr;
      rsp_ready = 1'b1;
      chk("vec_req_ready", 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      wr_en     = vecs[v].wr_en;
      wr_addr   = vecs[v].wr_addr;
      wr_data   = vecs[v].wr_data;
      chk("vec_rf_addr",     32'(rf_addr),   32'(vecs[v].addr));
      chk("vec_early_valid", 32'(rsp_valid), 32'd0);
      step();
      wr_en = 1'b0;
      chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("vec_rsp_data",  rsp_data,       vecs[v].exp_data);
      chk("vec_rsp_addr",  32'(rsp_addr),  32'(vecs[v].addr));
      chk("vec_cnt_hold",  32'(rd_cnt),    32'(exp_cnt));
      step();
      exp_cnt++;
      chk("vec_rsp_done", 32'(rsp_valid), 32'd0);
      chk("vec_cnt",      32'(rd_cnt),    32'(exp_cnt));
    end

    // Back-to-back reads 1..4 at full rate.
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        req_valid = 1'b1;
        req_addr  = 5'(i + 1);
        chk("b2b_req_ready", 32'(req_ready), 32'd1);
      end else begin
        req_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rsp_addr",  32'(rsp_addr),  32'(i));
        chk("b2b_rsp_data",  rsp_data,       b2b_exp[i-1]);
      end
    end
    step();
    exp_cnt += 4;
    chk("b2b_rsp_done", 32'(rsp_valid), 32'd0);
    chk("b2b_cnt",      32'(rd_cnt),    32'(exp_cnt));

    // Stall with both stages full, then a write to the held index.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 5'd8;
    step();
    req_addr = 5'd9;
    chk("stall_ready_2nd", 32'(req_ready), 32'd1);
    step();
    req_addr = 5'd10;
    chk("stall_ready_3rd", 32'(req_ready), 32'd0);
    wr_en   = 1'b1;
    wr_addr = 5'd8;
    wr_data = 32'hBAD0_0008;
    step();
    wr_en = 1'b0;
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_rsp_data",  rsp_data,       32'h1000_0008);
    chk("stall_rsp_addr",  32'(rsp_addr),  32'd8);
    chk("stall_rf_addr",   32'(rf_addr),   32'd9);
    chk("stall_ready_hold", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("drain_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("drain_rsp_addr",  32'(rsp_addr),  32'd9);
    chk("drain_rsp_data",  rsp_data,       32'h1000_0009);
    step();
    exp_cnt += 2;
    chk("drain_done", 32'(rsp_valid), 32'd0);
    chk("drain_cnt",  32'(rd_cnt),    32'(exp_cnt));

    // Reset in the middle of a cycle with both stages full.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 5'd11;
    step();
    req_addr = 5'd12;
    step();
    req_valid = 1'b0;
    chk("prerst_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("prerst_rsp_addr",  32'(rsp_addr),  32'd11);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cnt",       32'(rd_cnt),    32'(exp_cnt));
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_data",  rsp_data,       32'd0);
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("postrst_cnt", 32'(rd_cnt), 32'(exp_cnt));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
